wsum_seq_mac: RTL and testbench

- Parametrised, time-multiplexed weighted summer: y = sat(round(sum over i of coef[i]*x[i])).
- Coefficients are signed 1.(CW-1) fixed point, held in runtime-writable registers.
- A single DW x CW multiplier is shared across N_CH channels under an FSM, with a start/busy/done handshake.
- Successor to the fixed 3-input constant-coefficient datapath; drops into the same lab datapath slot.

---
 rtl/wsum_seq_mac.sv | 122 ++++++++++++
 tb/tb_wsum_seq_mac.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/wsum_seq_mac.sv
// Time-multiplexed weighted summer: one shared DW x CW multiplier walks N_CH
// channels, then rounds half toward +inf and saturates into a DW-bit result.
module wsum_seq_mac #(
  parameter int N_CH  = 3,
  parameter int DW    = 10,
  parameter int CW    = 12,
  parameter int CFRAC = 11
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [N_CH*DW-1:0]        x,
  input  logic                      coef_we,
  input  logic [$clog2(N_CH)-1:0]   coef_addr,
  input  logic signed [CW-1:0]      coef_wdata,
  output logic                      busy,
  output logic                      done,
  output logic signed [DW-1:0]      y,
  output logic                      ovf
);

  localparam int IW   = $clog2(N_CH);
  localparam int PW   = DW + CW;
  localparam int ACCW = PW + IW;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_MAC   = 2'd1;
  localparam logic [1:0] S_ROUND = 2'd2;

  localparam logic signed [CW-1:0]   C_NEG_HALF = CW'(-(1 << (CFRAC - 1)));
  localparam logic signed [CW-1:0]   C_FIVE_8TH = CW'((5 << CFRAC) >> 3);
  localparam logic signed [ACCW-1:0] RND_HALF   = ACCW'(1 << (CFRAC - 1));
  localparam logic signed [ACCW-1:0] Y_MAX      = ACCW'((1 << (DW - 1)) - 1);
  localparam logic signed [ACCW-1:0] Y_MIN      = ACCW'(-(1 << (DW - 1)));
  localparam logic signed [DW-1:0]   Y_MAX_DW   = DW'((1 << (DW - 1)) - 1);
  localparam logic signed [DW-1:0]   Y_MIN_DW   = DW'(-(1 << (DW - 1)));

  logic [1:0]               state;
  logic [IW-1:0]            idx;
  logic signed [ACCW-1:0]   acc;
  logic signed [DW-1:0]     xl   [N_CH];
  logic signed [CW-1:0]     coef [N_CH];

  logic signed [PW-1:0]     prod;
  logic signed [ACCW-1:0]   sum_rnd;
  logic signed [ACCW-1:0]   r;
  logic                     clamp_hi;
  logic                     clamp_lo;
  logic signed [DW-1:0]     y_next;
  logic                     addr_ok;

  always_comb begin
    prod     = '0;
    sum_rnd  = '0;
    r        = '0;
    clamp_hi = 1'b0;
    clamp_lo = 1'b0;
    y_next   = '0;
    addr_ok  = 1'b0;

    prod     = xl[idx] * coef[idx];
    sum_rnd  = acc + RND_HALF;
    r        = sum_rnd >>> CFRAC;
    clamp_hi = (r > Y_MAX);
    clamp_lo = (r < Y_MIN);
    if (clamp_hi)      y_next = Y_MAX_DW;
    else if (clamp_lo) y_next = Y_MIN_DW;
    else               y_next = r[DW-1:0];
    addr_ok  = (int'(coef_addr) < N_CH);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      y     <= '0;
      ovf   <= 1'b0;
      acc   <= '0;
      idx   <= '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
        xl[i] <= '0;
        if (i == 0 || i == 2) coef[i] <= C_NEG_HALF;
        else if (i == 1)      coef[i] <= C_FIVE_8TH;
        else                  coef[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          // Write lands at this edge; MAC reads coef from the next cycle on,
          // so a same-cycle start already sees the new value.
          if (coef_we && addr_ok) coef[coef_addr] <= coef_wdata;
          if (start) begin
            for (int unsigned i = 0; i < N_CH; i++) xl[i] <= x[i*DW +: DW];
            acc   <= '0;
            idx   <= '0;
            busy  <= 1'b1;
            state <= S_MAC;
          end
        end
        S_MAC: begin
          acc <= acc + ACCW'(prod);
          if (idx == IW'(N_CH - 1)) state <= S_ROUND;
          else                      idx   <= idx + IW'(1);
        end
        S_ROUND: begin
          y     <= y_next;
          ovf   <= clamp_hi | clamp_lo;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wsum_seq_mac.sv
// Directed bench for wsum_seq_mac with hand-computed results for 3 channels.
module tb_wsum_seq_mac;

  logic                clk = 1'b0;
  logic                reset;
  logic                start;
  logic [29:0]         x;
  logic                coef_we;
  logic [1:0]          coef_addr;
  logic signed [11:0]  coef_wdata;
  logic                busy;
  logic                done;
  logic signed [9:0]   y;
  logic                ovf;

  int n_asrt = 0;
  int n_fail = 0;
  int lat;
  int nbusy;
  int ndone;

  wsum_seq_mac #(.N_CH(3), .DW(10), .CW(12), .CFRAC(11)) dut (
    .clk(clk), .reset(reset), .start(start), .x(x),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .busy(busy), .done(done), .y(y), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_asrt++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_x(input int a, input int b, input int c);
    x = {10'(c), 10'(b), 10'(a)};
  endtask

  task automatic wr(input int a, input int v);
    coef_we = 1'b1; coef_addr = 2'(a); coef_wdata = 12'(v);
    tick();
    coef_we = 1'b0;
  endtask

  // Called right after the start edge; counts edges until done is seen.
  task automatic wait_done(output int n, output int nb);
    n = 0; nb = 0;
    while (done !== 1'b1 && n < 20) begin
      if (busy === 1'b1) nb++;
      tick();
      n++;
    end
  endtask

  task automatic run(input int a, input int b, input int c, output int n, output int nb);
    set_x(a, b, c);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(n, nb);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; x = '0;
    coef_we = 1'b0; coef_addr = '0; coef_wdata = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_y", y, 0);
    chk("rst_ovf", ovf, 0);

    // 1: default coefficients, all inputs 100
    run(100, 100, 100, lat, nbusy);
    chk("s1_lat", lat, 4);
    chk("s1_busy_cycles", nbusy, 4);
    chk("s1_busy_at_done", busy, 0);
    chk("s1_y", y, -37);
    chk("s1_ovf", ovf, 0);
    tick();
    chk("s1_done_pulse", done, 0);
    chk("s1_y_hold", y, -37);

    // 2: positive and negative saturation
    run(-512, 511, -512, lat, nbusy);
    chk("s2_pos_y", y, 511);
    chk("s2_pos_ovf", ovf, 1);
    run(511, -512, 511, lat, nbusy);
    chk("s2_neg_y", y, -512);
    chk("s2_neg_ovf", ovf, 1);

    // 3: rounding of -1.5 toward +inf, and near-unity coefficient
    wr(0, 12'h400); wr(1, 0); wr(2, 0);
    run(-3, 77, -99, lat, nbusy);
    chk("s3_round_y", y, -1);
    chk("s3_round_ovf", ovf, 0);
    wr(0, 0); wr(1, 12'h7FF);
    run(5, 200, -7, lat, nbusy);
    chk("s3_unity_y", y, 200);

    // restore defaults; an out-of-range address must not disturb anything
    wr(0, 12'hC00); wr(1, 12'h500); wr(2, 12'hC00);
    wr(3, 0);
    run(100, 100, 100, lat, nbusy);
    chk("s3_restore_y", y, -37);

    // 4: start and coef write while busy are both ignored
    set_x(100, 100, 100);
    start = 1'b1;
    tick();
    start = 1'b1; coef_we = 1'b1; coef_addr = 2'd1; coef_wdata = 12'h000;
    set_x(-512, 511, -512);
    tick();
    start = 1'b0; coef_we = 1'b0;
    wait_done(lat, nbusy);
    chk("s4_lat", lat, 3);
    chk("s4_y", y, -37);
    tick();
    chk("s4_no_requeue", busy, 0);
    run(100, 100, 100, lat, nbusy);
    chk("s4_coef_kept_y", y, -37);

    // 4b: start with a same-cycle write uses the new coefficient
    coef_we = 1'b1; coef_addr = 2'd1; coef_wdata = 12'h000;
    set_x(100, 100, 100);
    start = 1'b1;
    tick();
    start = 1'b0; coef_we = 1'b0;
    wait_done(lat, nbusy);
    chk("s4_same_cycle_y", y, -100);
    wr(1, 12'h500);

    // 5: x changes during MAC do not affect the result
    set_x(100, 100, 100);
    start = 1'b1;
    tick();
    start = 1'b0;
    set_x(-512, 511, -512);
    wait_done(lat, nbusy);
    chk("s5_latched_y", y, -37);

    // 5b: back-to-back start in the done cycle
    set_x(-512, 511, -512);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(lat, nbusy);
    chk("s5_b2b_lat", lat, 4);
    chk("s5_b2b_y", y, 511);
    chk("s5_b2b_ovf", ovf, 1);

    // 6: reset mid-MAC aborts and restores default coefficients
    wr(1, 0);
    set_x(100, 100, 100);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("s6_busy", busy, 0);
    chk("s6_done", done, 0);
    chk("s6_y", y, 0);
    chk("s6_ovf", ovf, 0);
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      if (done === 1'b1) ndone++;
      tick();
    end
    chk("s6_no_done", ndone, 0);
    run(100, 100, 100, lat, nbusy);
    chk("s6_after_y", y, -37);
    chk("s6_after_lat", lat, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
